// File: rtl/ysyx_040750_mcsr_if.sv
// Request/response bundle between the WB stage and the machine-mode CSR file.
// Interrupt levels ride along so the whole CSR-side contract lives in one place.
interface ysyx_040750_mcsr_if #(
    parameter int XLEN = 64,
    parameter int PC_W = 32
);
    logic              I_mtip;
    logic              I_msip;
    logic              I_meip;
    logic              I_wb_valid;
    logic              I_retire;
    logic              I_csr_wen;
    logic [1:0]        I_csr_op;
    logic [11:0]       I_csr_addr;
    logic [XLEN-1:0]   I_csr_src;
    logic              I_trap;
    logic [PC_W-1:0]   I_trap_pc;
    logic [XLEN-1:0]   I_trap_cause;
    logic              I_mret;
    logic [XLEN-1:0]   O_rd_data;
    logic              O_illegal;
    logic [PC_W-1:0]   O_trap_target;
    logic [PC_W-1:0]   O_mepc;
    logic              O_intr_req;
    logic [XLEN-1:0]   O_intr_cause;

    modport master (
        output I_mtip, I_msip, I_meip, I_wb_valid, I_retire, I_csr_wen, I_csr_op,
               I_csr_addr, I_csr_src, I_trap, I_trap_pc, I_trap_cause, I_mret,
        input  O_rd_data, O_illegal, O_trap_target, O_mepc, O_intr_req, O_intr_cause
    );

    modport slave (
        input  I_mtip, I_msip, I_meip, I_wb_valid, I_retire, I_csr_wen, I_csr_op,
               I_csr_addr, I_csr_src, I_trap, I_trap_pc, I_trap_cause, I_mret,
        output O_rd_data, O_illegal, O_trap_target, O_mepc, O_intr_req, O_intr_cause
    );
endinterface

// File: rtl/ysyx_040750_mcsr.sv
// Machine-mode CSR file: CSRRW/RS/RC, trap/mret state, mtvec targeting,
// interrupt arbitration and mcycle/minstret. Writes commit at WB, reads are combinational.
module ysyx_040750_mcsr #(
    parameter int XLEN   = 64,
    parameter int PC_W   = 32,
    parameter int CNT_EN = 1,
    parameter int VEC_EN = 1
) (
    input  logic                   I_sys_clk,
    input  logic                   I_rst,
    ysyx_040750_mcsr_if.slave      bus
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    localparam logic [XLEN-1:0] MSTATUS_FIX =
        (XLEN == 64) ? XLEN'(64'hA_0000_1800) : XLEN'(64'h1800);
    localparam logic [XLEN-1:0] LOW2       = XLEN'(3);
    localparam logic [XLEN-1:0] MTVEC_MASK = (VEC_EN != 0) ? ~XLEN'(2) : ~LOW2;

    logic            st_mie, st_mpie;
    logic [2:0]      mie_q;          // {MEIE, MTIE, MSIE}
    logic [2:0]      mip_q;          // {MEIP, MTIP, MSIP}
    logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mcycle_q, minstret_q;

    logic            hit, ro;
    logic [XLEN-1:0] rd, wdata;

    always_comb begin
        rd  = '0;
        hit = 1'b1;
        ro  = 1'b0;
        case (bus.I_csr_addr)
            A_MSTATUS: begin
                rd    = MSTATUS_FIX;
                rd[3] = st_mie;
                rd[7] = st_mpie;
            end
            A_MISA:     ro = 1'b1;
            A_MIE: begin
                rd[11] = mie_q[2];
                rd[7]  = mie_q[1];
                rd[3]  = mie_q[0];
            end
            A_MTVEC:    rd = mtvec_q;
            A_MSCRATCH: rd = mscratch_q;
            A_MEPC:     rd = mepc_q;
            A_MCAUSE:   rd = mcause_q;
            A_MIP: begin
                ro     = 1'b1;
                rd[11] = mip_q[2];
                rd[7]  = mip_q[1];
                rd[3]  = mip_q[0];
            end
            A_MCYCLE:   rd = (CNT_EN != 0) ? mcycle_q : '0;
            A_MINSTRET: rd = (CNT_EN != 0) ? minstret_q : '0;
            A_MHARTID:  ro = 1'b1;
            default:    hit = 1'b0;
        endcase
    end

    always_comb begin
        case (bus.I_csr_op)
            2'b01:   wdata = bus.I_csr_src;
            2'b10:   wdata = rd | bus.I_csr_src;
            2'b11:   wdata = rd & ~bus.I_csr_src;
            default: wdata = rd;
        endcase
    end

    logic illegal, take_trap, take_mret, csr_we, wr_mcycle, wr_minstret;
    assign illegal     = (bus.I_csr_op != 2'b00) && (!hit || ro);
    assign take_trap   = bus.I_wb_valid && bus.I_trap;
    assign take_mret   = bus.I_wb_valid && bus.I_mret && !bus.I_trap;
    // Trap and mret pre-empt a CSR write committing in the same cycle.
    assign csr_we      = bus.I_wb_valid && bus.I_csr_wen && (bus.I_csr_op != 2'b00) &&
                         !illegal && !bus.I_trap && !bus.I_mret;
    assign wr_mcycle   = csr_we && (bus.I_csr_addr == A_MCYCLE);
    assign wr_minstret = csr_we && (bus.I_csr_addr == A_MINSTRET);

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= '0;
            mip_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mip_q <= {bus.I_meip, bus.I_mtip, bus.I_msip};
            if (take_trap) begin
                mepc_q   <= XLEN'(bus.I_trap_pc) & ~LOW2;
                mcause_q <= bus.I_trap_cause;
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
            end else if (take_mret) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end else if (csr_we) begin
                case (bus.I_csr_addr)
                    A_MSTATUS: begin
                        st_mie  <= wdata[3];
                        st_mpie <= wdata[7];
                    end
                    A_MIE:      mie_q      <= {wdata[11], wdata[7], wdata[3]};
                    A_MTVEC:    mtvec_q    <= wdata & MTVEC_MASK;
                    A_MSCRATCH: mscratch_q <= wdata;
                    A_MEPC:     mepc_q     <= wdata & ~LOW2;
                    A_MCAUSE:   mcause_q   <= wdata;
                    default: ;
                endcase
            end
            // Counters run through trap cycles; an explicit write replaces the increment.
            if (CNT_EN != 0) begin
                mcycle_q <= wr_mcycle ? wdata : mcycle_q + 1'b1;
                if (wr_minstret)
                    minstret_q <= wdata;
                else if (bus.I_wb_valid && bus.I_retire)
                    minstret_q <= minstret_q + 1'b1;
            end
        end
    end

    logic [PC_W-1:0] tv_base, tv_off;
    assign tv_base = mtvec_q[PC_W-1:0] & ~PC_W'(3);
    assign tv_off  = {bus.I_trap_cause[PC_W-3:0], 2'b00};

    logic [2:0] pend;
    logic       intr_req;
    assign pend     = mip_q & mie_q;
    assign intr_req = st_mie && (pend != 3'b000);

    always_comb begin
        bus.O_intr_cause = '0;
        if (intr_req) begin
            bus.O_intr_cause[XLEN-1] = 1'b1;
            if (pend[2])      bus.O_intr_cause[3:0] = 4'd11;
            else if (pend[0]) bus.O_intr_cause[3:0] = 4'd3;
            else              bus.O_intr_cause[3:0] = 4'd7;
        end
    end

    assign bus.O_rd_data     = rd;
    assign bus.O_illegal     = illegal;
    assign bus.O_trap_target = (mtvec_q[0] && bus.I_trap_cause[XLEN-1]) ? tv_base + tv_off : tv_base;
    assign bus.O_mepc        = mepc_q[PC_W-1:0];
    assign bus.O_intr_req    = intr_req;
endmodule

// File: tb/tb_ysyx_040750_mcsr.sv
// Self-checking bench for ysyx_040750_mcsr: directed scenarios, then random traffic
// compared each cycle against an architectural CSR model.
module tb_ysyx_040750_mcsr;
    localparam int XLEN = 64;
    localparam int PC_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_040750_mcsr_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

    ysyx_040750_mcsr #(.XLEN(XLEN), .PC_W(PC_W), .CNT_EN(1), .VEC_EN(1)) dut (
        .I_sys_clk (clk),
        .I_rst     (rst),
        .bus       (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Architectural model state
    bit          m_mie, m_mpie;
    logic [63:0] m_mieen, m_mtvec, m_mscr, m_mepc, m_mcause, m_cyc, m_ins, m_mip;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_known(input logic [11:0] a);
        return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                         12'h342, 12'h344, 12'hB00, 12'hB02, 12'hF14};
    endfunction

    function automatic bit m_illegal(input logic [1:0] op, input logic [11:0] a);
        return (op != 2'b00) && (!m_known(a) || (a inside {12'h301, 12'h344, 12'hF14}));
    endfunction

    function automatic logic [63:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 64'hA_0000_1800 | (64'(m_mie) << 3) | (64'(m_mpie) << 7);
            12'h304: return m_mieen;
            12'h305: return m_mtvec;
            12'h340: return m_mscr;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip;
            12'hB00: return m_cyc;
            12'hB02: return m_ins;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_target(input logic [63:0] cause);
        logic [63:0] t;
        t = m_mtvec & ~64'h3;
        if (m_mtvec[0] && cause[63]) t = t + 4 * (cause & 64'h7FFF_FFFF_FFFF_FFFF);
        return t[31:0];
    endfunction

    function automatic logic [63:0] m_icause();
        logic [63:0] p;
        p = m_mip & m_mieen;
        if (!m_mie)   return 64'd0;
        if (p[11])    return 64'h8000_0000_0000_000B;
        if (p[3])     return 64'h8000_0000_0000_0003;
        if (p[7])     return 64'h8000_0000_0000_0007;
        return 64'd0;
    endfunction

    task automatic model_edge();
        logic [63:0] old, nw, ncyc, nins;
        if (rst) begin
            m_mie = 0; m_mpie = 0; m_mieen = 0; m_mtvec = 0; m_mscr = 0;
            m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ins = 0; m_mip = 0;
            return;
        end
        ncyc = m_cyc + 1;
        nins = m_ins + ((bus.I_wb_valid && bus.I_retire) ? 64'd1 : 64'd0);
        if (bus.I_wb_valid && bus.I_trap) begin
            m_mepc   = 64'(bus.I_trap_pc) & ~64'h3;
            m_mcause = bus.I_trap_cause;
            m_mpie   = m_mie;
            m_mie    = 0;
        end else if (bus.I_wb_valid && bus.I_mret) begin
            m_mie  = m_mpie;
            m_mpie = 1;
        end else if (bus.I_wb_valid && bus.I_csr_wen && bus.I_csr_op != 2'b00 &&
                     !m_illegal(bus.I_csr_op, bus.I_csr_addr)) begin
            old = m_read(bus.I_csr_addr);
            case (bus.I_csr_op)
                2'b01:   nw = bus.I_csr_src;
                2'b10:   nw = old | bus.I_csr_src;
                default: nw = old & ~bus.I_csr_src;
            endcase
            case (bus.I_csr_addr)
                12'h300: begin m_mie = nw[3]; m_mpie = nw[7]; end
                12'h304: m_mieen  = nw & 64'h888;
                12'h305: m_mtvec  = nw & ~64'h2;
                12'h340: m_mscr   = nw;
                12'h341: m_mepc   = nw & ~64'h3;
                12'h342: m_mcause = nw;
                12'hB00: ncyc     = nw;
                12'hB02: nins     = nw;
                default: ;
            endcase
        end
        m_cyc = ncyc;
        m_ins = nins;
        m_mip = (64'(bus.I_meip) << 11) | (64'(bus.I_mtip) << 7) | (64'(bus.I_msip) << 3);
    endtask

    task automatic check_all();
        chk("rd_data",     bus.O_rd_data, m_read(bus.I_csr_addr));
        chk("illegal",     64'(bus.O_illegal), 64'(m_illegal(bus.I_csr_op, bus.I_csr_addr)));
        chk("trap_target", 64'(bus.O_trap_target), 64'(m_target(bus.I_trap_cause)));
        chk("mepc",        64'(bus.O_mepc), 64'(m_mepc[31:0]));
        chk("intr_req",    64'(bus.O_intr_req), 64'(m_icause() != 64'd0));
        chk("intr_cause",  bus.O_intr_cause, m_icause());
    endtask

    // Check combinational outputs mid-cycle, then advance one edge.
    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        bus.I_wb_valid = 0; bus.I_retire = 0; bus.I_csr_wen = 0; bus.I_csr_op = 2'b00;
        bus.I_csr_addr = 12'h300; bus.I_csr_src = '0; bus.I_trap = 0;
        bus.I_trap_pc = '0; bus.I_trap_cause = '0; bus.I_mret = 0;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [63:0] src);
        idle();
        bus.I_wb_valid = 1; bus.I_csr_wen = 1; bus.I_csr_op = op;
        bus.I_csr_addr = a; bus.I_csr_src = src;
        tick();
        idle();
    endtask

    task automatic peek(input logic [11:0] a, input logic [63:0] exp, input string tag);
        bus.I_csr_addr = a;
        bus.I_csr_op   = 2'b00;
        #1;
        chk(tag, bus.O_rd_data, exp);
    endtask

    logic [11:0] addrs [14] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'h344, 12'hB00, 12'hB02, 12'hF14, 12'h7C0, 12'h000, 12'hB01};

    initial begin
        bus.I_mtip = 0; bus.I_msip = 0; bus.I_meip = 0;
        idle();
        rst = 1;
        @(posedge clk); model_edge();
        @(posedge clk); model_edge();
        #1;
        rst = 0;

        // Reset state and free-running mcycle
        repeat (10) tick();
        peek(12'hB00, 64'd10, "mcycle_after_10");
        peek(12'h300, 64'hA_0000_1800, "mstatus_reset");
        chk("reset_intr_req",   64'(bus.O_intr_req), 64'd0);
        chk("reset_intr_cause", bus.O_intr_cause, 64'd0);
        chk("reset_illegal",    64'(bus.O_illegal), 64'd0);
        chk("reset_mepc",       64'(bus.O_mepc), 64'd0);
        tick();

        // Timer interrupt with one-cycle mip latency
        csr(2'b10, 12'h304, 64'h80);
        csr(2'b10, 12'h300, 64'h8);
        bus.I_mtip = 1;
        #1;
        chk("mtip_before_sample", 64'(bus.O_intr_req), 64'd0);
        tick();
        chk("mtip_req",   64'(bus.O_intr_req), 64'd1);
        chk("mtip_cause", bus.O_intr_cause, 64'h8000_0000_0000_0007);

        // Priority MEI > MSI > MTI
        csr(2'b10, 12'h304, 64'h888);
        bus.I_meip = 1; bus.I_msip = 1; bus.I_mtip = 1;
        tick();
        chk("prio_mei", bus.O_intr_cause, 64'h8000_0000_0000_000B);
        bus.I_meip = 0;
        tick();
        chk("prio_msi", bus.O_intr_cause, 64'h8000_0000_0000_0003);
        bus.I_msip = 0;
        tick();
        chk("prio_mti", bus.O_intr_cause, 64'h8000_0000_0000_0007);
        bus.I_mtip = 0;
        tick();
        chk("intr_dropped", 64'(bus.O_intr_req), 64'd0);

        // Vectored trap then mret
        csr(2'b01, 12'h305, 64'h8000_0101);
        bus.I_wb_valid = 1; bus.I_trap = 1;
        bus.I_trap_cause = 64'h8000_0000_0000_0007; bus.I_trap_pc = 32'h8000_1236;
        #1;
        chk("vec_target", 64'(bus.O_trap_target), 64'h8000_011C);
        tick();
        idle();
        chk("trap_mepc", 64'(bus.O_mepc), 64'h8000_1234);
        peek(12'h300, 64'hA_0000_1880, "trap_mstatus");
        tick();
        bus.I_wb_valid = 1; bus.I_mret = 1;
        tick();
        idle();
        peek(12'h300, 64'hA_0000_1888, "mret_mstatus");
        tick();

        // Counter wrap and write-beats-increment
        csr(2'b01, 12'hB02, 64'hFFFF_FFFF_FFFF_FFFF);
        bus.I_wb_valid = 1; bus.I_retire = 1;
        tick();
        idle();
        peek(12'hB02, 64'd0, "minstret_wrap");
        tick();
        bus.I_wb_valid = 1; bus.I_csr_wen = 1; bus.I_csr_op = 2'b01;
        bus.I_csr_addr = 12'hB00; bus.I_csr_src = 64'd5; bus.I_retire = 1;
        tick();
        idle();
        peek(12'hB00, 64'd5, "mcycle_write_wins");
        peek(12'hB02, 64'd1, "minstret_retire");
        tick();

        // Illegal accesses
        bus.I_wb_valid = 1; bus.I_csr_wen = 1; bus.I_csr_op = 2'b01;
        bus.I_csr_addr = 12'h344; bus.I_csr_src = 64'hFFF;
        #1;
        chk("illegal_mip", 64'(bus.O_illegal), 64'd1);
        tick();
        idle();
        peek(12'h344, 64'd0, "mip_unchanged");
        bus.I_wb_valid = 1; bus.I_csr_wen = 1; bus.I_csr_op = 2'b01;
        bus.I_csr_addr = 12'h7C0; bus.I_csr_src = 64'h1;
        #1;
        chk("illegal_7c0",  64'(bus.O_illegal), 64'd1);
        chk("rd_7c0",       bus.O_rd_data, 64'd0);
        tick();
        idle();

        // Trap + mret + CSR write in one cycle: trap only
        bus.I_wb_valid = 1; bus.I_trap = 1; bus.I_mret = 1; bus.I_csr_wen = 1;
        bus.I_csr_op = 2'b01; bus.I_csr_addr = 12'h340; bus.I_csr_src = 64'h1234;
        bus.I_trap_pc = 32'h8000_2002; bus.I_trap_cause = 64'h2;
        tick();
        idle();
        peek(12'h340, 64'd0, "combo_mscratch");
        peek(12'h300, 64'hA_0000_1880, "combo_mstatus");
        chk("combo_mepc", 64'(bus.O_mepc), 64'h8000_2000);
        tick();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [63:0] c;
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 7) == 0) bus.I_mtip = ~bus.I_mtip;
            if ($urandom_range(0, 7) == 0) bus.I_msip = ~bus.I_msip;
            if ($urandom_range(0, 7) == 0) bus.I_meip = ~bus.I_meip;
            bus.I_wb_valid = ($urandom_range(0, 3) != 0);
            bus.I_retire   = 1'($urandom_range(0, 1));
            bus.I_csr_wen  = 1'($urandom_range(0, 1));
            bus.I_csr_op   = 2'($urandom_range(0, 3));
            bus.I_csr_addr = addrs[$urandom_range(0, 13)];
            bus.I_csr_src  = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom}
                                                         : 64'($urandom_range(0, 4095));
            bus.I_trap     = ($urandom_range(0, 15) == 0);
            bus.I_mret     = ($urandom_range(0, 7) == 0);
            bus.I_trap_pc  = $urandom;
            c = 64'($urandom_range(0, 31));
            c[63] = 1'($urandom_range(0, 1));
            bus.I_trap_cause = c;
            tick();
        end
        rst = 0;
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ysyx_040750_mcsr.md
Name: ysyx_040750_mcsr

Overview:
Parametrised machine-mode CSR file that supersedes the fixed 64-bit CSR unit in the full-pipeline core. It computes CSRRW/CSRRS/CSRRC results internally. It also arbitrates three prioritised interrupt sources (external, software, timer), supports direct and vectored mtvec, and maintains mcycle/minstret counters. It sits beside the WB stage: writes commit at WB, reads are combinational for the ID/EX forwarding path.

Parameters:
XLEN, 64, CSR data width (32 or 64)
PC_W, 32, width of PC fields supplied and returned
CNT_EN, 1, 1 = implement mcycle/minstret; 0 = both read 0 and ignore writes
VEC_EN, 1, 1 = mtvec MODE=1 (vectored) legal; 0 = MODE forced to 0

Ports:
I_sys_clk  input  1  clock
I_rst  input  1  synchronous active-high reset
I_mtip  input  1  timer interrupt level from CLINT
I_msip  input  1  software interrupt level from CLINT
I_meip  input  1  external interrupt level
I_wb_valid  input  1  qualifies every state-changing request below
I_retire  input  1  one instruction retired this cycle (minstret increment)
I_csr_wen  input  1  CSR instruction commits a write
I_csr_op  input  2  01 RW, 10 RS (set), 11 RC (clear), 00 none
I_csr_addr  input  12  CSR address, used for both read and write
I_csr_src  input  XLEN  rs1 value or zero-extended uimm
I_trap  input  1  take trap/interrupt this cycle
I_trap_pc  input  PC_W  PC saved to mepc
I_trap_cause  input  XLEN  cause written to mcause (bit XLEN-1 = interrupt)
I_mret  input  1  commit mret
O_rd_data  output  XLEN  current value of I_csr_addr (combinational)
O_illegal  output  1  I_csr_op!=00 and address unimplemented, or write to read-only CSR
O_trap_target  output  PC_W  handler address for I_trap_cause (combinational)
O_mepc  output  PC_W  mepc[PC_W-1:0] for mret redirect
O_intr_req  output  1  enabled interrupt pending
O_intr_cause  output  XLEN  cause of highest-priority pending interrupt

Behaviour:
- Implemented CSRs: mstatus 0x300, misa 0x301 (RO), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344 (RO), mcycle 0xB00, minstret 0xB02, mhartid 0xF14 (RO, 0). Other addresses read 0 and assert O_illegal.
- Reset values: mstatus=0xA00001800 (XLEN=64) or 0x1800 (XLEN=32); all other CSRs 0, including the mip sample register. With inputs idle after reset, O_intr_req=0, O_illegal=0, O_intr_cause=0, O_mepc=0.
- Write data: RW=src; RS=old|src; RC=old&~src. Commits on the rising edge when I_wb_valid&I_csr_wen&op!=00&!O_illegal.
- WARL masks: mstatus only MIE[3] and MPIE[7] are writable; MPP[12:11] is fixed 11. mie only bits 3, 7 and 11 are writable. mepc[1:0] is forced 0. mtvec[1] is forced 0, and mtvec[0] is forced 0 when VEC_EN=0.
- mip: bits 3, 7 and 11 are registered copies of msip, mtip and meip, with 1-cycle latency. Writes are ignored (illegal).
- Same-cycle priority for architectural state: reset > trap > mret > CSR write. A lower-priority request in the same cycle is dropped.
- Trap: mepc<=trap_pc with [1:0] forced 0; mcause<=trap_cause; MPIE<=MIE; MIE<=0.
- mret: MIE<=MPIE; MPIE<=1.
- O_trap_target: mtvec base is mtvec with [1:0] cleared. The target is base + 4*cause[XLEN-2:0] when MODE=1 and cause bit XLEN-1=1; otherwise it is base. The sum is truncated to PC_W.
- Interrupt arbitration: pend = mip&mie.
  - O_intr_req = MIE & |pend[11,7,3].
  - Priority: MEI(11) > MSI(3) > MTI(7).
  - O_intr_cause = {1, cause code}. It is 0 when no request is pending.
  - All are combinational from registered state: a new mtip edge shows on O_intr_req one cycle later.
- mcycle: increments every cycle, modulo 2^XLEN.
- minstret: increments when I_wb_valid&I_retire.
- Counter write in the same cycle as an increment: the written value wins, with no +1.
- Counter during a trap cycle: still increments (trap does not block counters).
- Reset asserted mid-operation restores all reset values on the next edge; in-flight requests are discarded.
- Any request with I_wb_valid=0 changes no state and does not affect the counter increment rules.

Test Plan:
- Reset, idle 10 cycles -> mstatus reads 0xA00001800, mcycle reads 10 (±1 by sample point), O_intr_req=0.
- CSRRS mie src=0x80, CSRRS mstatus src=0x8, raise I_mtip -> O_intr_req=1 exactly 1 cycle after mip sample, O_intr_cause=0x8000000000000007.
- Assert meip, msip, mtip together with all enabled -> cause code 11. Drop meip -> code 3. Drop msip -> code 7.
- mtvec<=0x80000101 (VEC_EN=1), I_trap cause=0x8000000000000007, pc=0x80001236 -> O_trap_target=0x8000011C. mepc=0x80001234, MIE=0, MPIE=1. Then mret -> MIE=1, MPIE=1.
- Write minstret=0xFFFFFFFFFFFFFFFF then retire one -> wraps to 0. Write mcycle=5 with retire/cycle increment same cycle -> reads 5 next cycle.
- CSRRW to 0x344, then 0x7C0 -> O_illegal=1, no state change. Trap+mret+CSR write same cycle -> only trap effects applied.
